// File: rtl/psg_pkg.sv
// Shared definitions for the PSG register writer: byte field positions,
// channel numbers, the queued request record and the writer FSM states.
package psg_pkg;

    localparam int LATCH_FLAG_BIT = 7;
    localparam int CH_HI          = 6;
    localparam int CH_LO          = 5;
    localparam int ATTEN_BIT      = 4;
    localparam int LOW_NIB_HI     = 3;
    localparam int DATA_HI        = 5;

    localparam logic [1:0] CH_TONE1 = 2'd0;
    localparam logic [1:0] CH_TONE2 = 2'd1;
    localparam logic [1:0] CH_TONE3 = 2'd2;
    localparam logic [1:0] CH_NOISE = 2'd3;

    typedef struct packed {
        logic [1:0] ch;
        logic       atten;
        logic [9:0] value;
    } psg_req_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LATCH = 3'd1,
        ST_GAP1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_GAP2  = 3'd4
    } psg_state_e;

    function automatic logic [7:0] latch_byte(input psg_req_t r);
        logic [7:0] b;
        b                       = '0;
        b[LATCH_FLAG_BIT]       = 1'b1;
        b[CH_HI:CH_LO]          = r.ch;
        b[ATTEN_BIT]            = r.atten;
        b[LOW_NIB_HI:0]         = r.value[3:0];
        return b;
    endfunction

    function automatic logic [7:0] data_byte(input psg_req_t r);
        logic [7:0] b;
        b             = '0;
        b[DATA_HI:0]  = r.value[9:4];
        return b;
    endfunction

    // Only tone-frequency writes carry a second (data) byte.
    function automatic logic is_tone_freq(input psg_req_t r);
        return !r.atten && (r.ch != CH_NOISE);
    endfunction

endpackage

// File: rtl/psg_wr_fifo.sv
// Synchronous request FIFO for the PSG writer; show-ahead read port,
// registered occupancy count with full/empty flags.
module psg_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 13
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == (AW + 1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/psg_writer.sv
// Serialises queued channel updates into PSG write-port bytes, spacing
// every wren pulse by a fixed number of idle clocks.
module psg_writer
    import psg_pkg::*;
#(
    parameter int GAP_CYCLES = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_ch,
    input  logic       req_atten,
    input  logic [9:0] req_value,
    output logic [7:0] wrdata,
    output logic       wren,
    output logic       busy,
    output logic [2:0] state_dbg
);

    // The counter holds idle clocks still to come after the current one, so
    // a gap state expires exactly GAP_CYCLES clocks after the pulse ended.
    localparam logic [7:0] GAP_LOAD = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);

    psg_state_e state, state_n;
    logic [7:0] cnt, cnt_n;
    logic       wren_n;
    logic [7:0] wrdata_n;
    psg_req_t   cur, cur_n;
    psg_req_t   new_req;
    psg_req_t   fifo_rdata;
    logic       fifo_push;
    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       take_next;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    // Handshake: a request transfers on a rising edge with req_valid and
    // req_ready both high; req_ready depends only on the registered count.
    assign req_ready = !fifo_full;
    assign fifo_push = req_valid && req_ready;
    assign new_req   = '{ch: req_ch, atten: req_atten, value: req_value};
    assign busy      = (fifo_count != '0) || (state != ST_IDLE);
    assign state_dbg = state;

    psg_wr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(psg_req_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .wdata   (new_req),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            wren   <= 1'b0;
            wrdata <= 8'h00;
            cur    <= '0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            wren   <= wren_n;
            wrdata <= wrdata_n;
            cur    <= cur_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        wren_n    = 1'b0;
        wrdata_n  = wrdata;
        cur_n     = cur;
        fifo_pop  = 1'b0;
        take_next = 1'b0;

        case (state)
            ST_IDLE:  take_next = 1'b1;
            ST_LATCH: begin
                cnt_n   = GAP_LOAD;
                state_n = ST_GAP1;
            end
            ST_GAP1: begin
                if (cnt == '0) begin
                    if (is_tone_freq(cur)) begin
                        wrdata_n = data_byte(cur);
                        wren_n   = 1'b1;
                        state_n  = ST_DATA;
                    end else begin
                        take_next = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ST_DATA: begin
                cnt_n   = GAP_LOAD;
                state_n = ST_GAP2;
            end
            ST_GAP2: begin
                if (cnt == '0) begin
                    take_next = 1'b1;
                    state_n   = ST_IDLE;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase

        // Expired gaps start the next queued request directly so continuous
        // work keeps the spacing exact instead of losing a clock in IDLE.
        if (take_next && !fifo_empty) begin
            fifo_pop = 1'b1;
            cur_n    = fifo_rdata;
            wrdata_n = latch_byte(fifo_rdata);
            wren_n   = 1'b1;
            state_n  = ST_LATCH;
        end
    end

endmodule

// File: tb/tb_psg_writer.sv
// Directed bench for psg_writer: one instance at a 32-clock gap, one at zero
// gap; wren bytes and their cycle stamps are scored against hand-derived values.
module tb_psg_writer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] req_ch;
    logic       req_atten;
    logic [9:0] req_value;
    logic       valid_a, ready_a, wren_a, busy_a;
    logic [7:0] wrdata_a;
    logic [2:0] state_a;
    logic       valid_b, ready_b, wren_b, busy_b;
    logic [7:0] wrdata_b;
    logic [2:0] state_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int push_cyc = 0;
    int idle_cyc;
    int adj_a    = 0;
    int adj_b    = 0;
    logic prev_a = 1'b0;
    logic prev_b = 1'b0;
    bit   saw_full = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] got_a[$];
    logic [7:0] got_b[$];
    int         t_a[$];
    int         t_b[$];

    logic [1:0] bp_ch[6]    = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic       bp_atten[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [9:0] bp_val[6]   = '{10'h123, 10'h005, 10'h3C0, 10'h004, 10'h00F, 10'h001};
    logic [7:0] bp_exp[9]   = '{8'h83, 8'h12, 8'hB5, 8'hC0, 8'h3C, 8'hE4, 8'h9F, 8'hA1, 8'h00};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    psg_writer #(.GAP_CYCLES(32), .FIFO_DEPTH(4)) dut_a (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (valid_a),
        .req_ready (ready_a),
        .req_ch    (req_ch),
        .req_atten (req_atten),
        .req_value (req_value),
        .wrdata    (wrdata_a),
        .wren      (wren_a),
        .busy      (busy_a),
        .state_dbg (state_a)
    );

    psg_writer #(.GAP_CYCLES(0), .FIFO_DEPTH(4)) dut_b (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (valid_b),
        .req_ready (ready_b),
        .req_ch    (req_ch),
        .req_atten (req_atten),
        .req_value (req_value),
        .wrdata    (wrdata_b),
        .wren      (wren_b),
        .busy      (busy_b),
        .state_dbg (state_b)
    );

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (wren_a) begin
            got_a.push_back(wrdata_a);
            t_a.push_back(cyc);
        end
        if (wren_b) begin
            got_b.push_back(wrdata_b);
            t_b.push_back(cyc);
        end
        if (wren_a && prev_a) adj_a++;
        if (wren_b && prev_b) adj_b++;
        prev_a = wren_a;
        prev_b = wren_b;
        if (!ready_a) saw_full = 1'b1;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic score(input string tag, input bit sel);
        logic [7:0] g[$];
        int n;
        g = sel ? got_b : got_a;
        check_eq({tag, "_nbytes"}, g.size(), exp_q.size());
        n = (g.size() < exp_q.size()) ? g.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check_eq($sformatf("%s_byte%0d", tag, i), g[i], exp_q[i]);
        exp_q.delete();
        got_a.delete();
        got_b.delete();
        t_a.delete();
        t_b.delete();
    endtask

    // ---------------- drivers ----------------
    task automatic send(input bit sel, input logic [1:0] ch, input logic atten, input logic [9:0] val);
        bit ok;
        bit done;
        ok   = 1'b0;
        done = 1'b0;
        @(negedge clk);
        req_ch    = ch;
        req_atten = atten;
        req_value = val;
        if (sel) valid_b = 1'b1;
        else     valid_a = 1'b1;
        for (int i = 0; i < 500; i++) begin
            ok = sel ? ready_b : ready_a;
            @(posedge clk);
            if (ok) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        valid_a  = 1'b0;
        valid_b  = 1'b0;
        push_cyc = cyc;
        if (!done) check_eq("send_timeout", ok, 1);
    endtask

    task automatic wait_idle(input bit sel, output int idle_at);
        logic b;
        b       = 1'b1;
        idle_at = -1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            b = sel ? busy_b : busy_a;
            if (!b) begin
                idle_at = cyc;
                break;
            end
        end
        if (idle_at < 0) check_eq("idle_timeout", b, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset_n   = 1'b0;
        valid_a   = 1'b0;
        valid_b   = 1'b0;
        req_ch    = 2'd0;
        req_atten = 1'b0;
        req_value = 10'h000;
        #1;
        check_eq("rst_wren", wren_a, 0);
        check_eq("rst_wrdata", wrdata_a, 8'h00);
        check_eq("rst_ready", ready_a, 1);
        check_eq("rst_busy", busy_a, 0);
        check_eq("rst_state", state_a, 0);
        check_eq("rst_ready_b", ready_b, 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // single tone: latch then data, 32 low clocks between pulses
        send(0, 2'd1, 1'b0, 10'h2A5);
        wait_idle(0, idle_cyc);
        check_eq("tone_pulses", t_a.size(), 2);
        if (t_a.size() >= 2) begin
            check_eq("tone_latency", t_a[0] - push_cyc, 1);
            check_eq("tone_spacing", t_a[1] - t_a[0], 33);
            check_eq("tone_busy_tail", idle_cyc - t_a[1], 33);
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h2A);
        score("tone", 0);

        // attenuation: one byte, busy drops after the trailing gap
        send(0, 2'd2, 1'b1, 10'h007);
        wait_idle(0, idle_cyc);
        if (t_a.size() >= 1) check_eq("atten_busy_tail", idle_cyc - t_a[0], 33);
        exp_q.push_back(8'hD7);
        score("atten", 0);

        // noise control: one byte, no data byte
        send(0, 2'd3, 1'b0, 10'h006);
        wait_idle(0, idle_cyc);
        exp_q.push_back(8'hE6);
        score("noise", 0);

        // back-pressure: six requests into a four-deep queue
        saw_full = 1'b0;
        for (int i = 0; i < 6; i++) send(0, bp_ch[i], bp_atten[i], bp_val[i]);
        wait_idle(0, idle_cyc);
        check_eq("bp_saw_full", saw_full, 1);
        for (int i = 1; i < t_a.size(); i++)
            check_eq($sformatf("bp_gap%0d", i), t_a[i] - t_a[i-1], 33);
        for (int i = 0; i < 9; i++) exp_q.push_back(bp_exp[i]);
        score("bp", 0);

        // zero gap: pulses one low clock apart
        send(1, 2'd0, 1'b0, 10'h3FF);
        wait_idle(1, idle_cyc);
        if (t_b.size() >= 2) check_eq("gap0_spacing", t_b[1] - t_b[0], 2);
        exp_q.push_back(8'h8F);
        exp_q.push_back(8'h3F);
        score("gap0_tone", 1);

        send(1, 2'd2, 1'b1, 10'h001);
        send(1, 2'd3, 1'b0, 10'h002);
        wait_idle(1, idle_cyc);
        if (t_b.size() >= 2) check_eq("gap0_chain_spacing", t_b[1] - t_b[0], 2);
        exp_q.push_back(8'hD1);
        exp_q.push_back(8'hE2);
        score("gap0_chain", 1);
        check_eq("gap0_adjacent", adj_b, 0);
        check_eq("gap32_adjacent", adj_a, 0);

        // reset between latch and data byte, with a second request queued
        send(0, 2'd1, 1'b0, 10'h2A5);
        send(0, 2'd2, 1'b1, 10'h007);
        for (int i = 0; i < 100; i++) begin
            if (got_a.size() >= 1) break;
            @(negedge clk);
            #1;
        end
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_wren", wren_a, 0);
        check_eq("midrst_ready", ready_a, 1);
        check_eq("midrst_busy", busy_a, 0);
        check_eq("midrst_state", state_a, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (80) @(negedge clk);
        #1;
        check_eq("midrst_busy_after", busy_a, 0);
        exp_q.push_back(8'hA5);
        score("midrst", 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
